multdiv_ctrl: RTL and testbench
===============================

Name: multdiv_ctrl

Overview:
- Multi-cycle sequencer for signed 32-bit multiply and divide that sits beside the ALU in the execute stage.
- Starts an operation from a one-cycle ctrl_MULT/ctrl_DIV pulse and latches the operands.
- Drives one shared WIDTH-bit adder/subtractor iteratively: shift-add for multiply, restoring subtract for divide.
- Reports a one-cycle ready pulse plus an exception flag that the pipeline stall logic consumes.

Parameters:
- WIDTH, 32, operand/result width. The iteration counter is clog2(WIDTH)+1 bits.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high.
- ctrl_MULT  input  1  start pulse for a signed multiply.
- ctrl_DIV  input  1  start pulse for a signed divide (quotient only).
- data_operandA  input  WIDTH  multiplicand / dividend. Sampled only in the start cycle.
- data_operandB  input  WIDTH  multiplier / divisor. Sampled only in the start cycle.
- data_result  output  WIDTH  product low word or quotient.
- data_exception  output  1  overflow or divide-by-zero. Valid while data_resultRDY is high.
- data_resultRDY  output  1  one-cycle completion pulse.
- busy  output  1  high from the cycle after an accepted start through the DONE cycle.

Behaviour:
- Clocking: one clock domain. Reset is synchronous and active-high.
- Reset: state IDLE, counter 0, all internal registers 0. Outputs on reset: data_result=0, data_exception=0, data_resultRDY=0, busy=0. Reset mid-operation aborts it; no RDY pulse is issued for the aborted operation.
- States:
  - IDLE: sample starts.
  - MUL: iterate multiply.
  - DIV: iterate divide.
  - DONE: one cycle, RDY high, then return to IDLE.
- Start acceptance: only in IDLE or DONE. Starts in MUL/DIV are ignored (no queueing). If ctrl_MULT and ctrl_DIV are high together, the multiply wins.
- Start cycle: latch |A|, |B|, and the result sign (A[msb] XOR B[msb]). Clear the 2*WIDTH accumulator and load counter = WIDTH.
- MUL, each cycle:
  - If acc LSB multiplier bit is 1, add |A| into the upper half.
  - Shift the accumulator right by 1 and decrement the counter.
  - Go to DONE when the counter reaches 0.
- DIV, each cycle:
  - Shift {remainder, quotient} left by 1 and compute trial = remainder − |B|.
  - If trial is non-negative, remainder=trial and set quotient LSB; otherwise restore.
  - Decrement the counter.
- Latency, start in cycle 0: data_resultRDY is high in cycle WIDTH+1 (cycle 33 at the default) for exactly one cycle.
- Sign fix-up: applied when entering DONE. The result is negated if the sign is 1 and the magnitude is non-zero.
- Multiply overflow:
  - Exception if the 2*WIDTH signed product does not fit in WIDTH signed bits, i.e. the upper word is not the sign-extension of result[msb].
  - On overflow, data_result = low word (wrapped).
- Divide by zero (B==0):
  - Skip DIV; the start edge goes directly to DONE, so RDY is high in cycle 1.
  - data_result=0 and data_exception=1.
- Divide overflow (A=0x80000000, B=0xFFFFFFFF): runs the full latency, then data_result=0x80000000 and data_exception=1.
- Divide rounding: truncation toward zero. The remainder is discarded.
- Output hold: data_result and data_exception hold their last values until the next accepted start. data_exception is cleared on an accepted start.
- Back-to-back: a start in the DONE cycle is accepted, so the next operation's RDY comes WIDTH+1 cycles later.

Optional Feature:
- Macro: MULTDIV_EARLY_EXIT_EN.
- When defined: in MUL, if the remaining unshifted multiplier bits are all 0, finish the remaining shifts in one cycle and go to DONE next cycle. Let p be the index of the highest set bit of |B|. RDY then occurs in cycle p+2; for |B|==0, RDY occurs in cycle 1. DIV latency is unchanged.
- When undefined: fixed latency WIDTH+1 for every non-divide-by-zero operation.

Test Plan:
- ctrl_MULT, A=7, B=−6 (0xFFFFFFFA) -> cycle 33: RDY=1, result=0xFFFFFFD6 (−42), exception=0. With MULTDIV_EARLY_EXIT_EN, RDY in cycle 4.
- ctrl_MULT, A=0x00010000, B=0x00010000 -> cycle 33: RDY=1, exception=1, result=0x00000000.
- ctrl_DIV, A=−100, B=7 -> cycle 33: result=0xFFFFFFF2 (−14), exception=0. Then ctrl_DIV in the DONE cycle with A=0x80000000, B=−1 -> 33 cycles later: result=0x80000000, exception=1.
- ctrl_DIV, A=5, B=0 -> cycle 1: RDY=1, result=0, exception=1. busy=0 in cycle 2.
- ctrl_MULT and ctrl_DIV together, A=3, B=4 -> result=12. A ctrl_DIV pulse in cycle 10 is ignored: exactly one RDY, in cycle 33.
- ctrl_MULT A=9, B=9, then reset in cycle 10 -> no RDY through cycle 40 and all outputs 0. A fresh ctrl_MULT A=2, B=3 in cycle 12 -> RDY in cycle 45, result=6.

Source files
------------

// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl
// Multi-cycle sequencer for signed multiply and divide in the execute stage.
// One shared WIDTH-bit adder/subtractor is reused every cycle: it adds for
// shift-add multiply and subtracts for restoring divide. A result is reported
// with a one-cycle data_resultRDY pulse and an exception flag.
//
// Ports:
//   clock          in   rising-edge clock
//   reset          in   synchronous, active-high
//   ctrl_MULT      in   one-cycle start pulse, signed multiply (wins over DIV)
//   ctrl_DIV       in   one-cycle start pulse, signed divide (quotient only)
//   data_operandA  in   multiplicand / dividend, sampled in the start cycle
//   data_operandB  in   multiplier / divisor, sampled in the start cycle
//   data_result    out  product low word or quotient, held until the next result
//   data_exception out  overflow or divide-by-zero, cleared on an accepted start
//   data_resultRDY out  one-cycle completion pulse
//   busy           out  high from the cycle after a start through the DONE cycle
//
// Optional feature: define MULTDIV_EARLY_EXIT_EN to let a multiply finish as
// soon as the remaining multiplier bits are all zero.

module multdiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_t;

  state_t             state, state_next;
  logic [CW-1:0]      count, count_next;
  logic [2*WIDTH-1:0] acc, acc_next;
  logic [WIDTH-1:0]   mag_a, mag_a_next;
  logic [WIDTH-1:0]   mag_b, mag_b_next;
  logic               sign, sign_next;
  logic [WIDTH-1:0]   result_next;
  logic               exception_next;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH-1:0]   add_a, add_b;
  logic               add_sub;
  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] mul_step, div_shift, div_step;
  logic [2*WIDTH-1:0] signed_val;

  // Negate a magnitude when the result sign is set; zero stays zero.
  function automatic logic [2*WIDTH-1:0] apply_sign(input logic neg,
                                                    input logic [2*WIDTH-1:0] mag);
    if (neg && (mag != '0))
      return ~mag + 1'b1;
    return mag;
  endfunction

  // Shared adder/subtractor. In DIV it subtracts the divisor from the
  // remainder after the left shift; bit WIDTH of the sum is then the borrow.
  // In MUL it adds the multiplicand into the upper half; bit WIDTH is the carry.
  always_comb begin
    add_sub = (state == DIV);
    add_a   = (state == DIV) ? acc[2*WIDTH-2:WIDTH-1] : acc[2*WIDTH-1:WIDTH];
    add_b   = (state == DIV) ? mag_b : mag_a;
  end

  assign add_sum = {1'b0, add_a}
                 + ({1'b0, add_b} ^ {(WIDTH+1){add_sub}})
                 + {{WIDTH{1'b0}}, add_sub};

  // One iteration of each algorithm. The multiply carry is shifted back in
  // at the top; the divide keeps the remainder only when no borrow occurred.
  always_comb begin
    mul_step  = acc[0] ? {add_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
    div_shift = {acc[2*WIDTH-2:0], 1'b0};
    div_step  = add_sum[WIDTH] ? div_shift
                               : {add_sum[WIDTH-1:0], div_shift[WIDTH-1:1], 1'b1};
  end

  assign abs_a = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
  assign abs_b = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;

`ifdef MULTDIV_EARLY_EXIT_EN
  // Multiplier bits still waiting to be consumed sit in acc[count-1:1]
  // (bit 0 is consumed this cycle); product bits above them are excluded.
  logic [WIDTH-1:0] mul_rest_mask;
  logic             mul_rest_zero;

  assign mul_rest_mask = ({WIDTH{1'b1}} >> (CW'(WIDTH) - count))
                       & ~{{(WIDTH-1){1'b0}}, 1'b1};
  assign mul_rest_zero = ((acc[WIDTH-1:0] & mul_rest_mask) == '0);
`endif

  // Next-state and datapath control. The sign fix-up and the exception
  // decision are made on the transition into DONE so the registered result
  // is already valid in the RDY cycle.
  always_comb begin
    state_next     = state;
    count_next     = count;
    acc_next       = acc;
    mag_a_next     = mag_a;
    mag_b_next     = mag_b;
    sign_next      = sign;
    result_next    = data_result;
    exception_next = data_exception;
    signed_val     = '0;

    case (state)
      IDLE, DONE: begin
        if (ctrl_MULT || ctrl_DIV) begin
          mag_a_next     = abs_a;
          mag_b_next     = abs_b;
          sign_next      = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
          count_next     = CW'(WIDTH);
          exception_next = 1'b0;
          if (ctrl_MULT) begin
            acc_next   = {{WIDTH{1'b0}}, abs_b};
            state_next = MUL;
`ifdef MULTDIV_EARLY_EXIT_EN
            if (abs_b == '0) begin
              acc_next    = '0;
              count_next  = '0;
              result_next = '0;
              state_next  = DONE;
            end
`endif
          end else begin
            acc_next   = {{WIDTH{1'b0}}, abs_a};
            state_next = DIV;
            if (data_operandB == '0) begin
              acc_next       = '0;
              count_next     = '0;
              result_next    = '0;
              exception_next = 1'b1;
              state_next     = DONE;
            end
          end
        end else if (state == DONE) begin
          state_next = IDLE;
        end
      end

      MUL: begin
        acc_next   = mul_step;
        count_next = count - 1'b1;
`ifdef MULTDIV_EARLY_EXIT_EN
        // No more adds can happen, so the remaining shifts collapse into one.
        if (mul_rest_zero) begin
          acc_next   = mul_step >> (count - 1'b1);
          count_next = '0;
        end
`endif
        if (count_next == '0) begin
          state_next     = DONE;
          signed_val     = apply_sign(sign, acc_next);
          result_next    = signed_val[WIDTH-1:0];
          exception_next = (signed_val[2*WIDTH-1:WIDTH] != {WIDTH{signed_val[WIDTH-1]}});
        end
      end

      DIV: begin
        acc_next   = div_step;
        count_next = count - 1'b1;
        if (count_next == '0) begin
          state_next     = DONE;
          signed_val     = apply_sign(sign, {{WIDTH{1'b0}}, div_step[WIDTH-1:0]});
          result_next    = signed_val[WIDTH-1:0];
          // Only the most-negative / -1 case yields a positive quotient with
          // the top bit set.
          exception_next = ~sign & div_step[WIDTH-1];
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      count          <= '0;
      acc            <= '0;
      mag_a          <= '0;
      mag_b          <= '0;
      sign           <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else begin
      state          <= state_next;
      count          <= count_next;
      acc            <= acc_next;
      mag_a          <= mag_a_next;
      mag_b          <= mag_b_next;
      sign           <= sign_next;
      data_result    <= result_next;
      data_exception <= exception_next;
    end
  end

  assign data_resultRDY = (state == DONE);
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_multdiv_ctrl.sv
// tb_multdiv_ctrl
// Scoreboard bench for multdiv_ctrl. Each start pushes the expected cycle,
// result and exception; a monitor on the falling edge pops and compares
// whenever data_resultRDY is high. Cycle numbers count rising edges.

module tb_multdiv_ctrl;

  localparam int WIDTH = 32;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             ctrl_MULT = 1'b0;
  logic             ctrl_DIV = 1'b0;
  logic [WIDTH-1:0] data_operandA = '0;
  logic [WIDTH-1:0] data_operandB = '0;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  multdiv_ctrl #(.WIDTH(WIDTH)) dut (
    .clock         (clock),
    .reset         (reset),
    .ctrl_MULT     (ctrl_MULT),
    .ctrl_DIV      (ctrl_DIV),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .data_result   (data_result),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY),
    .busy          (busy)
  );

  typedef struct {
    int               due;
    logic [WIDTH-1:0] res;
    logic             exc;
  } exp_t;

  exp_t sb[$];
  exp_t monEntry;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   t, lm, ign;

  // Free-running clock and cycle counter.
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Hand-derived multiply latency: 33 normally, p+2 with early exit.
  function automatic int mulLatency(input logic [31:0] b);
    logic [31:0] m;
    int p;
    m = b[31] ? (~b + 1) : b;
    p = -1;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
`ifdef MULTDIV_EARLY_EXIT_EN
    return (p < 0) ? 1 : p + 2;
`else
    return (p < -1) ? 0 : 33;
`endif
  endfunction

  // Advance to the given cycle, 1 time unit after its rising edge.
  task automatic goToCycle(input int n);
    if (cyc > n) begin
      checks++;
      errors++;
      $display("[TB] FAIL schedule: at cycle %0d, target %0d", cyc, n);
    end
    while (cyc < n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Drive a one-cycle start in the current cycle; lat <= 0 means no result expected.
  task automatic applyStimulus(input logic mul, input logic div,
                               input logic [31:0] opA, input logic [31:0] opB,
                               input int lat, input logic [31:0] res,
                               input logic exc);
    exp_t e;
    ctrl_MULT     = mul;
    ctrl_DIV      = div;
    data_operandA = opA;
    data_operandB = opB;
    if (lat > 0) begin
      e.due = cyc + lat;
      e.res = res;
      e.exc = exc;
      sb.push_back(e);
    end
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = 32'hDEADBEEF;
    data_operandB = 32'h0BADF00D;
  endtask

  // Monitor: every RDY pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (data_resultRDY === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("rdy_unexpected", {31'b0, data_resultRDY}, 32'd0);
      end else begin
        monEntry = sb.pop_front();
        checkOutput("rdy_cycle", cyc, monEntry.due);
        checkOutput("result", data_result, monEntry.res);
        checkOutput("exception", {31'b0, data_exception}, {31'b0, monEntry.exc});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset_result", data_result, 32'd0);
    checkOutput("reset_exception", {31'b0, data_exception}, 32'd0);
    checkOutput("reset_rdy", {31'b0, data_resultRDY}, 32'd0);
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // 7 * -6 = -42
    t  = cyc;
    lm = mulLatency(32'hFFFFFFFA);
    applyStimulus(1'b1, 1'b0, 32'd7, 32'hFFFFFFFA, lm, 32'hFFFFFFD6, 1'b0);
    goToCycle(t + lm + 3);
    checkOutput("hold_result", data_result, 32'hFFFFFFD6);
    checkOutput("hold_exception", {31'b0, data_exception}, 32'd0);

    // 0x10000 * 0x10000 overflows, low word 0
    t  = cyc;
    lm = mulLatency(32'h00010000);
    applyStimulus(1'b1, 1'b0, 32'h00010000, 32'h00010000, lm, 32'h0, 1'b1);
    goToCycle(t + lm + 2);

    // -100 / 7 = -14, then back-to-back most-negative / -1
    t = cyc;
    applyStimulus(1'b0, 1'b1, -100, 32'd7, 33, 32'hFFFFFFF2, 1'b0);
    checkOutput("exception_cleared_on_start", {31'b0, data_exception}, 32'd0);
    checkOutput("busy_div", {31'b0, busy}, 32'd1);
    goToCycle(t + 33);
    applyStimulus(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 33, 32'h80000000, 1'b1);
    checkOutput("busy_back_to_back", {31'b0, busy}, 32'd1);
    goToCycle(t + 33 + 33 + 2);

    // 5 / 0: RDY next cycle, exception set
    t = cyc;
    applyStimulus(1'b0, 1'b1, 32'd5, 32'd0, 1, 32'h0, 1'b1);
    checkOutput("busy_div0_done", {31'b0, busy}, 32'd1);
    goToCycle(t + 2);
    checkOutput("busy_div0_after", {31'b0, busy}, 32'd0);

    // MULT and DIV together: multiply wins; a DIV pulse mid-operation is ignored
    t   = cyc;
    lm  = mulLatency(32'd4);
    ign = (lm == 33) ? 10 : 2;
    applyStimulus(1'b1, 1'b1, 32'd3, 32'd4, lm, 32'd12, 1'b0);
    goToCycle(t + ign);
    applyStimulus(1'b0, 1'b1, 32'd100, 32'd5, 0, 32'h0, 1'b0);
    goToCycle(t + 45);
    checkOutput("hold_mul_result", data_result, 32'd12);

    // Reset mid-multiply aborts it; a fresh multiply then runs normally
    t  = cyc;
    lm = mulLatency(32'd9);
    applyStimulus(1'b1, 1'b0, 32'd9, 32'd9, (lm < 10) ? lm : 0, 32'd81, 1'b0);
    goToCycle(t + 10);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    checkOutput("abort_result", data_result, 32'd0);
    checkOutput("abort_exception", {31'b0, data_exception}, 32'd0);
    checkOutput("abort_rdy", {31'b0, data_resultRDY}, 32'd0);
    checkOutput("abort_busy", {31'b0, busy}, 32'd0);
    goToCycle(t + 12);
    lm = mulLatency(32'd3);
    applyStimulus(1'b1, 1'b0, 32'd2, 32'd3, lm, 32'd6, 1'b0);
    goToCycle(t + 12 + lm + 3);

    checkOutput("scoreboard_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
